// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: widths, reset PC, NOP encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package if_stage_pkg;

    localparam int          INSTR_W      = 32;
    localparam int          ADDR_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_DEF      = 32'h0000_0000;
    localparam int          CNT_W_DEF    = 16;

    // Where the next PC value comes from this cycle
    typedef enum logic [1:0] {
        PC_SRC_HOLD   = 2'd0,
        PC_SRC_SEQ    = 2'd1,
        PC_SRC_BRANCH = 2'd2,
        PC_SRC_JUMP   = 2'd3
    } pc_src_e;

    // Branch is resolved in an older stage than a jump, so it wins a tie
    function automatic pc_src_e pc_src_sel(input logic branch_taken,
                                           input logic jump,
                                           input logic pc_write);
        pc_src_e src;
        if (branch_taken)  src = PC_SRC_BRANCH;
        else if (jump)     src = PC_SRC_JUMP;
        else if (pc_write) src = PC_SRC_SEQ;
        else               src = PC_SRC_HOLD;
        return src;
    endfunction

endpackage

// File: rtl/if_stage_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, clears on reset.
// Latency: count reflects an inc one cycle after it is sampled.
// Backpressure: none; inc is a pure event input.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         at_max;

    assign at_max = &count_q;

    // Advance only while below the ceiling
    always_comb begin
        count_d = count_q;
        if (inc && !at_max) count_d = count_q + W'(1);
    end

    // Synchronous clear, otherwise take the next value
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register plus IF/ID register, honouring hazard stalls and redirects.
// Latency: word fetched at PC p appears on instr_fd one cycle after imem_addr = p.
// Backpressure: PCWrite/IFIDWrite low hold state; a redirect overrides both holds.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEF[ADDR_W-1:0],
    parameter logic [31:0]       NOP_INSTR = NOP_DEF,
    parameter int                CNT_W     = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCWrite,
    input  logic               IFIDWrite,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc_fd,
    output logic [INSTR_W-1:0] instr_fd,
    output logic               valid_fd,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   flush_count
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_fd_q, pc_fd_d;
    logic [INSTR_W-1:0] instr_fd_q, instr_fd_d;
    logic               valid_fd_q, valid_fd_d;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               redirect;
    pc_src_e            pc_src;
    logic               stall_inc;
    logic               flush_inc;

    // Wraps silently at the top of the address space
    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign redirect = branch_taken | jump;
    assign pc_src   = pc_src_sel(branch_taken, jump, PCWrite);

    // Next PC: redirect beats the stall hold
    always_comb begin
        pc_d = pc_q;
        case (pc_src)
            PC_SRC_BRANCH: pc_d = branch_target;
            PC_SRC_JUMP:   pc_d = jump_target;
            PC_SRC_SEQ:    pc_d = pc_plus4;
            default:       pc_d = pc_q;
        endcase
    end

    // Next IF/ID: a redirect squashes the wrong-path word into a bubble
    always_comb begin
        pc_fd_d    = pc_fd_q;
        instr_fd_d = instr_fd_q;
        valid_fd_d = valid_fd_q;
        if (redirect) begin
            pc_fd_d    = '0;
            instr_fd_d = NOP_INSTR;
            valid_fd_d = 1'b0;
        end else if (IFIDWrite) begin
            pc_fd_d    = pc_plus4;
            instr_fd_d = imem_rdata;
            valid_fd_d = 1'b1;
        end
    end

    // PC and IF/ID registers with synchronous reset to an empty pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            pc_fd_q    <= '0;
            instr_fd_q <= NOP_INSTR;
            valid_fd_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_fd_q    <= pc_fd_d;
            instr_fd_q <= instr_fd_d;
            valid_fd_q <= valid_fd_d;
        end
    end

    // A cycle counts as a stall only if the PC is actually frozen
    assign stall_inc = !PCWrite && !redirect;
    assign flush_inc = redirect;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

    assign imem_addr = pc_q;
    assign pc_fd     = pc_fd_q;
    assign instr_fd  = instr_fd_q;
    assign valid_fd  = valid_fd_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: table of hand-computed cycle vectors checked through a scoreboard queue.
// Latency: each vector is checked 1 ns after the edge that consumes it.
// Backpressure: none; the bench drives the hazard controls directly.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset, PCWrite, IFIDWrite, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] imem_addr, imem_rdata, pc_fd, instr_fd;
    logic        valid_fd;
    logic [15:0] stall_count, flush_count;
    // Second instance with 2-bit counters to exercise saturation
    logic [31:0] s_addr, s_pcfd, s_instr;
    logic        s_vld;
    logic [1:0]  s_stall, s_flush;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory image: word at address a is a+1 (imem[i] = i*4+1)
    assign imem_rdata = imem_addr + 32'd1;

    if_stage dut (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .pc_fd(pc_fd), .instr_fd(instr_fd), .valid_fd(valid_fd),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    if_stage #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_addr(s_addr), .imem_rdata(imem_rdata),
        .pc_fd(s_pcfd), .instr_fd(s_instr), .valid_fd(s_vld),
        .stall_count(s_stall), .flush_count(s_flush)
    );

    typedef struct {
        logic        rst;
        logic        pcw;
        logic        ifw;
        logic        br;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic [31:0] e_addr;
        logic [31:0] e_pcfd;
        logic [31:0] e_instr;
        logic        e_vld;
        int          e_st;
        int          e_fl;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl [NV];
    vec_t sb [$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic drive(input vec_t v);
        reset         = v.rst;
        PCWrite       = v.pcw;
        IFIDWrite     = v.ifw;
        branch_taken  = v.br;
        branch_target = v.bt;
        jump          = v.j;
        jump_target   = v.jt;
        sb.push_back(v);
    endtask

    task automatic check_out(input int idx);
        vec_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", idx, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("imem_addr",   idx, imem_addr, e.e_addr);
        chk("pc_fd",       idx, pc_fd, e.e_pcfd);
        chk("instr_fd",    idx, instr_fd, e.e_instr);
        chk("valid_fd",    idx, {31'd0, valid_fd}, {31'd0, e.e_vld});
        chk("stall_count", idx, {16'd0, stall_count}, e.e_st);
        chk("flush_count", idx, {16'd0, flush_count}, e.e_fl);
        chk("s_addr",      idx, s_addr, e.e_addr);
        chk("s_pcfd",      idx, s_pcfd, e.e_pcfd);
        chk("s_instr",     idx, s_instr, e.e_instr);
        chk("s_valid",     idx, {31'd0, s_vld}, {31'd0, e.e_vld});
        chk("s_stall_sat", idx, {30'd0, s_stall}, sat3(e.e_st));
        chk("s_flush_sat", idx, {30'd0, s_flush}, sat3(e.e_fl));
    endtask

    initial begin
        //          rst pcw ifw br  bt            j   jt             addr           pcfd           instr          v   st  fl
        tbl[0]  = '{1, 0, 0, 0, 32'h0,        0, 32'h0,         32'h0,         32'h0,         32'h0,         0,  0,  0};
        tbl[1]  = '{0, 1, 1, 0, 32'h0,        0, 32'h0,         32'h4,         32'h4,         32'h1,         1,  0,  0};
        tbl[2]  = '{0, 1, 1, 0, 32'h0,        0, 32'h0,         32'h8,         32'h8,         32'h5,         1,  0,  0};
        tbl[3]  = '{0, 1, 1, 0, 32'h0,        0, 32'h0,         32'hC,         32'hC,         32'h9,         1,  0,  0};
        tbl[4]  = '{0, 1, 1, 0, 32'h0,        0, 32'h0,         32'h10,        32'h10,        32'hD,         1,  0,  0};
        // three stall cycles at PC=0x10, then resume
        tbl[5]  = '{0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h10,        32'h10,        32'hD,         1,  1,  0};
        tbl[6]  = '{0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h10,        32'h10,        32'hD,         1,  2,  0};
        tbl[7]  = '{0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h10,        32'h10,        32'hD,         1,  3,  0};
        tbl[8]  = '{0, 1, 1, 0, 32'h0,        0, 32'h0,         32'h14,        32'h14,        32'h11,        1,  3,  0};
        // branch during a stall
        tbl[9]  = '{0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h14,        32'h14,        32'h11,        1,  4,  0};
        tbl[10] = '{0, 0, 0, 1, 32'h40,       0, 32'h0,         32'h40,        32'h0,         32'h0,         0,  4,  1};
        tbl[11] = '{0, 1, 1, 0, 32'h0,        0, 32'h0,         32'h44,        32'h44,        32'h41,        1,  4,  1};
        // branch and jump together: branch wins
        tbl[12] = '{0, 1, 1, 1, 32'h80,       1, 32'h100,       32'h80,        32'h0,         32'h0,         0,  4,  2};
        tbl[13] = '{0, 1, 1, 0, 32'h0,        0, 32'h0,         32'h84,        32'h84,        32'h81,        1,  4,  2};
        // jump to the last word, then wrap
        tbl[14] = '{0, 1, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         32'h0,         0,  4,  3};
        tbl[15] = '{0, 1, 1, 0, 32'h0,        0, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFD, 1,  4,  3};
        tbl[16] = '{0, 1, 1, 0, 32'h0,        0, 32'h0,         32'h4,         32'h4,         32'h1,         1,  4,  3};
        // back-to-back redirects, second one with PCWrite low
        tbl[17] = '{0, 1, 1, 0, 32'h0,        1, 32'h200,       32'h200,       32'h0,         32'h0,         0,  4,  4};
        tbl[18] = '{0, 0, 0, 1, 32'h300,      0, 32'h0,         32'h300,       32'h0,         32'h0,         0,  4,  5};
        tbl[19] = '{0, 1, 1, 0, 32'h0,        0, 32'h0,         32'h304,       32'h304,       32'h301,       1,  4,  5};
        // independent controls: drop a word, then re-latch one
        tbl[20] = '{0, 1, 0, 0, 32'h0,        0, 32'h0,         32'h308,       32'h304,       32'h301,       1,  4,  5};
        tbl[21] = '{0, 0, 1, 0, 32'h0,        0, 32'h0,         32'h308,       32'h30C,       32'h309,       1,  5,  5};
        tbl[22] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h308,       32'h30C,       32'h309,       1,  6,  5};
        // reset during a stall with a redirect pending: all inputs ignored
        tbl[23] = '{1, 0, 0, 1, 32'h500,      1, 32'h600,       32'h0,         32'h0,         32'h0,         0,  0,  0};
        tbl[24] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h0,         32'h0,         32'h0,         0,  1,  0};
        tbl[25] = '{0, 0, 0, 0, 32'h0,        0, 32'h0,         32'h0,         32'h0,         32'h0,         0,  2,  0};
        tbl[26] = '{1, 0, 0, 0, 32'h0,        0, 32'h0,         32'h0,         32'h0,         32'h0,         0,  0,  0};
        tbl[27] = '{0, 1, 1, 0, 32'h0,        0, 32'h0,         32'h4,         32'h4,         32'h1,         1,  0,  0};

        reset = 1'b1; PCWrite = 1'b0; IFIDWrite = 1'b0;
        branch_taken = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check_out(i);
        end

        // Long stall: wide counter keeps counting, narrow one pins at 3
        PCWrite = 1'b0; IFIDWrite = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
        end
        chk("long_stall_count", 100, {16'd0, stall_count}, 32'd20);
        chk("long_stall_sat",   100, {30'd0, s_stall}, 32'd3);
        chk("long_stall_addr",  100, imem_addr, 32'h4);
        chk("long_stall_instr", 100, instr_fd, 32'h1);

        // Fetch resumes where it froze
        PCWrite = 1'b1; IFIDWrite = 1'b1;
        @(posedge clk);
        #1;
        chk("resume_addr",  101, imem_addr, 32'h8);
        chk("resume_instr", 101, instr_fd, 32'h5);
        chk("resume_pcfd",  101, pc_fd, 32'h8);
        chk("resume_stall", 101, {16'd0, stall_count}, 32'd20);
        chk("sb_drained",   101, sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage for the five-stage MIPS pipeline: owns the PC register and the IF/ID pipeline register and honours the stall controls produced by the hazard detection unit (PCWrite, IFIDWrite) together with branch/jump redirects from later stages. It drives the instruction-memory address, holds the fetched instruction stable while the pipeline stalls, and replaces it with a NOP bubble on a redirect. Saturating stall and flush counters expose pipeline efficiency to the bench and debug logic.

## Interface

Parameters:
- ADDR_W, 32, PC / address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0000, instruction word inserted on flush (sll $0,$0,0)
- CNT_W, 16, width of stall/flush counters

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- PCWrite  in  1  1 = PC may advance; 0 = hold PC (from hazard unit)
- IFIDWrite  in  1  1 = IF/ID may load; 0 = hold IF/ID (from hazard unit)
- branch_taken  in  1  taken branch resolved downstream; redirect PC
- branch_target  in  ADDR_W  branch destination
- jump  in  1  jump decoded in ID; redirect PC
- jump_target  in  ADDR_W  jump destination
- imem_addr  out  ADDR_W  instruction-memory address (= PC register)
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- pc_fd  out  ADDR_W  IF/ID: PC+4 of the held instruction
- instr_fd  out  32  IF/ID: instruction word
- valid_fd  out  1  IF/ID: 1 = real instruction, 0 = bubble
- stall_count  out  CNT_W  cycles stalled (saturating)
- flush_count  out  CNT_W  redirects taken (saturating)

## Operation

- Redirect = branch_taken | jump. Redirect target: branch_target if branch_taken, else jump_target (branch is older, wins on simultaneous assertion).
- PC next value, priority: reset → RESET_PC; redirect → target (overrides PCWrite=0); PCWrite=1 → PC+4; else hold.
- IF/ID next value, priority: reset → {pc_fd=0, instr_fd=NOP_INSTR, valid_fd=0}; redirect → same bubble (overrides IFIDWrite=0); IFIDWrite=1 → {PC+4, imem_rdata, 1}; else hold all three.
- PCWrite and IFIDWrite are applied independently; no cross-check. PCWrite=1/IFIDWrite=0 drops the fetched word; PCWrite=0/IFIDWrite=1 re-latches the same word. The hazard unit always drives them equal.
- PC+4 arithmetic is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0 without flag.
- stall_count: +1 in each cycle with PCWrite=0 and no redirect and no reset. flush_count: +1 in each redirect cycle. Both saturate at all-ones and clear on reset.

## Timing

- Reset values: imem_addr=RESET_PC, pc_fd=0, instr_fd=NOP_INSTR, valid_fd=0, stall_count=0, flush_count=0.
- Fetch latency: instruction at PC p appears on instr_fd/valid_fd=1 one cycle after imem_addr=p.
- Stall: PCWrite=IFIDWrite=0 in cycle t → imem_addr, pc_fd, instr_fd, valid_fd unchanged at t+1; resume at first cycle both return to 1.
- Redirect in cycle t → imem_addr=target and bubble (valid_fd=0) at t+1; target instruction on instr_fd at t+2. Redirect during stall behaves identically (stall does not delay redirect).
- Back-to-back redirects: each one loads its own target and a bubble; flush_count increments every cycle.
- Reset asserted mid-stall or mid-redirect: reset values at next edge, all inputs ignored that cycle.
- No combinational path from inputs to outputs except imem_rdata → none (imem_addr is registered PC only).

## Structure

- Shared pipeline package: NOP_INSTR, RESET_PC default, ADDR_W, instruction width 32.
- One sub-module: sat_counter (parameter width, inputs clk/reset/inc, output count, saturating at all-ones), instantiated twice for stall_count and flush_count.

## Test plan

- Reset, then free-run with imem[i]=i*4+1 → imem_addr 0,4,8,…; instr_fd lags by one cycle; valid_fd=1 from cycle 2; counters 0.
- PCWrite=IFIDWrite=0 for 3 cycles at PC=0x10 → imem_addr stays 0x10, instr_fd/pc_fd frozen, stall_count=3; fetch resumes at 0x14 afterwards.
- branch_taken=1, target 0x40, during a stall → imem_addr=0x40 next cycle, valid_fd=0, instr_fd=NOP, flush_count=1, stall_count unchanged; instr at 0x40 following cycle.
- branch_taken=1 (0x80) and jump=1 (0x100) same cycle → imem_addr=0x80, flush_count +1 only.
- PC=0xFFFF_FFFC free-run → next imem_addr=0; with CNT_W=2 and 5 stall cycles → stall_count=3 (saturated).
- Reset asserted during a stall with stall_count=2 → next cycle imem_addr=RESET_PC, valid_fd=0, both counters 0.
